delay_timer_arbiter: RTL and testbench

//  Shares one WIDTH-bit up-counter among N_REQ requesters that each need a timed delay.
//  - Each requester asks for a delay of len cycles.
//  - Round-robin arbitration picks one requester and grants it the counter.
//  - The block counts up from 0 and pulses that requester's done when len cycles have elapsed.
//  - It sits between control FSMs (debounce, display multiplexing, timeouts) and the single shared counter.

---
 rtl/delay_timer_arbiter.sv | 127 ++++++++++++
 tb/tb_delay_timer_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter that lends one shared up-counter to N_REQ delay requesters; grant 1 cycle after req, done target cycles after grant.
// No backpressure: a requester holds req until done. Dropping req while owning the counter cancels the delay silently.
module delay_timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     len,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           done,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic [WIDTH-1:0]           count
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  target_q, target_d;

  logic [WIDTH-1:0]  len_a [N_REQ];
  logic [IW-1:0]     win;
  logic              found;
  logic [IW-1:0]     next_ptr;

  for (genvar i = 0; i < N_REQ; i++) begin : g_len
    assign len_a[i] = len[i*WIDTH +: WIDTH];
  end

  // First set request scanning upward from rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[IW'((int'(rr_ptr_q) + k) % N_REQ)]) begin
        found = 1'b1;
        win   = IW'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
  end

  assign next_ptr = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    target_d = target_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        count_d = '0;
        if (found) begin
          grant_d  = N_REQ'(1) << win;
          owner_d  = win;
          target_d = (len_a[win] == '0) ? WIDTH'(1) : len_a[win];
          state_d  = S_COUNT;
        end
      end
      S_COUNT: begin
        // A dropped request beats an expiry landing on the same edge.
        if (!req[owner_q]) begin
          state_d  = S_IDLE;
          grant_d  = '0;
          count_d  = '0;
          rr_ptr_d = next_ptr;
        end else if (count_q == target_q - WIDTH'(1)) begin
          count_d = target_q;
          done_d  = grant_q;
          state_d = S_DONE;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        grant_d  = '0;
        count_d  = '0;
        rr_ptr_d = next_ptr;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      target_q <= target_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = |grant_q;
  assign owner = owner_q;
  assign count = count_q;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed bench for delay_timer_arbiter: reset, single delay, round-robin, zero length, cancel, cancel vs expiry.
module tb_delay_timer_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*W-1:0]    len;
  logic [N-1:0]      grant;
  logic [N-1:0]      done;
  logic              busy;
  logic [1:0]        owner;
  logic [W-1:0]      count;

  int n_vec = 0;
  int n_err = 0;

  delay_timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .owner (owner),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; len = '0;
    tick(); tick();
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000); end
    n_vec++; if (done !== 4'b0000) begin n_err++; $display("FAIL reset_done: got %b expected %b", done, 4'b0000); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (owner !== 2'd0) begin n_err++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    n_vec++; if (count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
    reset = 1'b0;
    len[0*W +: W] = 32'd20;
    req = 4'b0001;
    tick();
    n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t1_grant: got %b expected %b", grant, 4'b0001); end
    repeat (5) tick();
    n_vec++; if (count !== 32'd5) begin n_err++; $display("FAIL t1_count5: got %0d expected 5", count); end
    reset = 1'b1;
    tick();
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t1_grant_after_reset: got %b expected %b", grant, 4'b0000); end
    n_vec++; if (count !== 32'd0) begin n_err++; $display("FAIL t1_count_after_reset: got %0d expected 0", count); end
    n_vec++; if (done !== 4'b0000) begin n_err++; $display("FAIL t1_done_after_reset: got %b expected %b", done, 4'b0000); end
    reset = 1'b0;
    req = '0;
    for (int c = 0; c < 30; c++) begin
      tick();
      n_vec++; if (done !== 4'b0000) begin n_err++; $display("FAIL t1_no_done cycle %0d: got %b expected %b", c, done, 4'b0000); end
    end
  endtask

  task automatic test_single();
    do_reset();
    len[2*W +: W] = 32'd10;
    req = 4'b0100;
    tick();
    n_vec++; if (grant !== 4'b0100) begin n_err++; $display("FAIL t2_grant: got %b expected %b", grant, 4'b0100); end
    n_vec++; if (owner !== 2'd2) begin n_err++; $display("FAIL t2_owner: got %0d expected 2", owner); end
    n_vec++; if (count !== 32'd0) begin n_err++; $display("FAIL t2_count0: got %0d expected 0", count); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL t2_busy: got %b expected 1", busy); end
    repeat (4) tick();
    len[2*W +: W] = 32'd3;
    repeat (5) tick();
    n_vec++; if (done !== 4'b0000) begin n_err++; $display("FAIL t2_done_early: got %b expected %b", done, 4'b0000); end
    n_vec++; if (count !== 32'd9) begin n_err++; $display("FAIL t2_count9: got %0d expected 9", count); end
    tick();
    n_vec++; if (done !== 4'b0100) begin n_err++; $display("FAIL t2_done: got %b expected %b", done, 4'b0100); end
    n_vec++; if (count !== 32'd10) begin n_err++; $display("FAIL t2_count10: got %0d expected 10", count); end
    req = '0;
    tick();
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t2_grant_release: got %b expected %b", grant, 4'b0000); end
    n_vec++; if (done !== 4'b0000) begin n_err++; $display("FAIL t2_done_clear: got %b expected %b", done, 4'b0000); end
    n_vec++; if (count !== 32'd0) begin n_err++; $display("FAIL t2_count_clear: got %0d expected 0", count); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t2_busy_clear: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < N; i++) len[i*W +: W] = 32'd3;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      tick();
      n_vec++; if (grant !== exp_g) begin n_err++; $display("FAIL t3_grant[%0d]: got %b expected %b", k, grant, exp_g); end
      n_vec++; if (owner !== 2'(k % 4)) begin n_err++; $display("FAIL t3_owner[%0d]: got %0d expected %0d", k, owner, k % 4); end
      tick(); tick();
      n_vec++; if (done !== 4'b0000) begin n_err++; $display("FAIL t3_done_early[%0d]: got %b expected %b", k, done, 4'b0000); end
      tick();
      n_vec++; if (done !== exp_g) begin n_err++; $display("FAIL t3_done[%0d]: got %b expected %b", k, done, exp_g); end
      n_vec++; if (count !== 32'd3) begin n_err++; $display("FAIL t3_count[%0d]: got %0d expected 3", k, count); end
      if (k == 4) req = '0;
      tick();
      n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t3_gap[%0d]: got %b expected %b", k, grant, 4'b0000); end
    end
  endtask

  task automatic test_len_zero();
    do_reset();
    len[1*W +: W] = 32'd0;
    req = 4'b0010;
    tick();
    n_vec++; if (grant !== 4'b0010) begin n_err++; $display("FAIL t4_grant: got %b expected %b", grant, 4'b0010); end
    tick();
    n_vec++; if (done !== 4'b0010) begin n_err++; $display("FAIL t4_done: got %b expected %b", done, 4'b0010); end
    n_vec++; if (count !== 32'd1) begin n_err++; $display("FAIL t4_count: got %0d expected 1", count); end
    req = '0;
    tick();
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t4_release: got %b expected %b", grant, 4'b0000); end
  endtask

  task automatic test_cancel();
    do_reset();
    len[0*W +: W] = 32'd100;
    len[1*W +: W] = 32'd5;
    req = 4'b0011;
    tick();
    n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t5_grant0: got %b expected %b", grant, 4'b0001); end
    repeat (40) tick();
    n_vec++; if (count !== 32'd40) begin n_err++; $display("FAIL t5_count40: got %0d expected 40", count); end
    req = 4'b0010;
    tick();
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t5_cancel_grant: got %b expected %b", grant, 4'b0000); end
    n_vec++; if (done !== 4'b0000) begin n_err++; $display("FAIL t5_cancel_done: got %b expected %b", done, 4'b0000); end
    n_vec++; if (count !== 32'd0) begin n_err++; $display("FAIL t5_cancel_count: got %0d expected 0", count); end
    tick();
    n_vec++; if (grant !== 4'b0010) begin n_err++; $display("FAIL t5_grant1: got %b expected %b", grant, 4'b0010); end
    n_vec++; if (owner !== 2'd1) begin n_err++; $display("FAIL t5_owner1: got %0d expected 1", owner); end
    repeat (5) tick();
    n_vec++; if (done !== 4'b0010) begin n_err++; $display("FAIL t5_done1: got %b expected %b", done, 4'b0010); end
    req = '0;
    tick();
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t5_release: got %b expected %b", grant, 4'b0000); end
  endtask

  task automatic test_cancel_vs_expiry();
    do_reset();
    len[3*W +: W] = 32'd4;
    req = 4'b1000;
    tick();
    n_vec++; if (grant !== 4'b1000) begin n_err++; $display("FAIL t6_grant3: got %b expected %b", grant, 4'b1000); end
    repeat (3) tick();
    n_vec++; if (count !== 32'd3) begin n_err++; $display("FAIL t6_count3: got %0d expected 3", count); end
    req = '0;
    tick();
    n_vec++; if (done !== 4'b0000) begin n_err++; $display("FAIL t6_done: got %b expected %b", done, 4'b0000); end
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t6_grant_clear: got %b expected %b", grant, 4'b0000); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t6_busy: got %b expected 0", busy); end
    n_vec++; if (count !== 32'd0) begin n_err++; $display("FAIL t6_count: got %0d expected 0", count); end
    req = 4'b1111;
    tick();
    n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t6_rr_wrap: got %b expected %b", grant, 4'b0001); end
    n_vec++; if (owner !== 2'd0) begin n_err++; $display("FAIL t6_owner: got %0d expected 0", owner); end
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    len   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_len_zero();
    test_cancel();
    test_cancel_vs_expiry();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
